flash_responder: RTL and testbench

Serial-flash responder: the device end of the SPI link that our flash reader drives. It decodes SPI mode-0 commands from an initiator and answers READ (0x03), READ STATUS (0x05) and, optionally, JEDEC ID (0x9F) from an external byte memory. It sits between the board SPI pins (or a simulation SPI master) and a synchronous byte ROM/RAM holding the boot/config image, so configuration fetches run in simulation and on boards without a physical flash.

---
 rtl/flash_responder_if.sv | 16 +
 rtl/flash_responder.sv | 208 ++++++++++++++++++++
 tb/tb_flash_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/flash_responder_if.sv
// SPI pins and byte-memory read port of flash_responder.
// master = initiator/memory side, slave = responder side.
interface flash_responder_if #(
  parameter int AW = 24
);
  logic          cs;
  logic          ck;
  logic          mosi;
  logic          miso;
  logic          rd;
  logic [AW-1:0] a;
  logic [7:0]    q;

  modport master (output cs, ck, mosi, q, input miso, rd, a);
  modport slave  (input cs, ck, mosi, q, output miso, rd, a);
endinterface

// File: rtl/flash_responder.sv
// SPI mode-0 flash device: READ/READ STATUS from a byte memory, JEDEC ID when FLASH_RESPONDER_JEDEC_EN is defined.
// Pins act 3 clocks after they change (2-FF sync + edge detect); no backpressure, memory must return q one clock after rd.
module flash_responder #(
  parameter int          AW       = 24,
  parameter logic [7:0]  STATUS   = 8'h00
`ifdef FLASH_RESPONDER_JEDEC_EN
  , parameter logic [23:0] JEDEC_ID = 24'hEF4018
`endif
) (
  input logic              clock,
  input logic              reset,
  flash_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_STAT,
`ifdef FLASH_RESPONDER_JEDEC_EN
    S_ID,
`endif
    S_IGNORE
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    cs_sy, ck_sy, mosi_sy;
  logic          cs_d, ck_d;
  logic          cs_s, ck_s, mosi_s;
  logic          ck_rise, ck_fall, cs_fall;
  logic [4:0]    cnt, cnt_nxt;
  logic [7:0]    cmd_sh, cmd_nxt;
  logic [23:0]   addr, addr_nxt;
  logic [7:0]    tx, tx_nxt;
  logic          miso_r, miso_nxt;
  logic          rd_r, rd_nxt;
  logic [AW-1:0] a_r, a_nxt;
  logic          cap;
`ifdef FLASH_RESPONDER_JEDEC_EN
  logic [1:0]    idx, idx_nxt;
`endif

  assign cs_s    = cs_sy[1];
  assign ck_s    = ck_sy[1];
  assign mosi_s  = mosi_sy[1];
  assign ck_rise = ck_s & ~ck_d;
  assign ck_fall = ~ck_s & ck_d;
  assign cs_fall = ~cs_s & cs_d;

  assign bus.miso = miso_r;
  assign bus.rd   = rd_r;
  assign bus.a    = a_r;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cmd_nxt   = cmd_sh;
    addr_nxt  = addr;
    tx_nxt    = tx;
    miso_nxt  = miso_r;
    rd_nxt    = 1'b0;
    a_nxt     = a_r;
`ifdef FLASH_RESPONDER_JEDEC_EN
    idx_nxt   = idx;
`endif
    case (state)
      S_IDLE: begin
        miso_nxt = 1'b1;
        cnt_nxt  = '0;
        if (cs_fall) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (ck_rise) begin
          cmd_nxt = {cmd_sh[6:0], mosi_s};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_nxt = '0;
            case (cmd_nxt)
              8'h03: state_nxt = S_ADDR;
              8'h05: begin
                state_nxt = S_STAT;
                tx_nxt    = STATUS;
              end
`ifdef FLASH_RESPONDER_JEDEC_EN
              8'h9F: begin
                state_nxt = S_ID;
                tx_nxt    = JEDEC_ID[23:16];
                idx_nxt   = 2'd1;
              end
`endif
              default: state_nxt = S_IGNORE;
            endcase
          end
        end
      end
      S_ADDR: begin
        if (ck_rise) begin
          addr_nxt = {addr[22:0], mosi_s};
          cnt_nxt  = cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt_nxt   = '0;
            rd_nxt    = 1'b1;
            a_nxt     = addr_nxt[AW-1:0];
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        // memory answers one clock after rd; cap marks that clock
        if (cap) tx_nxt = bus.q;
        if (ck_fall) begin
          miso_nxt = tx[7];
          tx_nxt   = {tx[6:0], 1'b1};
        end
        if (ck_rise) begin
          cnt_nxt = cnt + 5'd1;
          if (cnt[2:0] == 3'd7) begin
            cnt_nxt  = '0;
            addr_nxt = addr + 24'd1;
            rd_nxt   = 1'b1;
            a_nxt    = addr_nxt[AW-1:0];
          end
        end
      end
      S_STAT: begin
        if (ck_fall) begin
          miso_nxt = tx[7];
          tx_nxt   = {tx[6:0], 1'b1};
        end
        if (ck_rise) begin
          cnt_nxt = cnt + 5'd1;
          if (cnt[2:0] == 3'd7) begin
            cnt_nxt = '0;
            tx_nxt  = STATUS;
          end
        end
      end
`ifdef FLASH_RESPONDER_JEDEC_EN
      S_ID: begin
        if (ck_fall) begin
          miso_nxt = tx[7];
          tx_nxt   = {tx[6:0], 1'b1};
        end
        if (ck_rise) begin
          cnt_nxt = cnt + 5'd1;
          if (cnt[2:0] == 3'd7) begin
            cnt_nxt = '0;
            case (idx)
              2'd1:    tx_nxt = JEDEC_ID[15:8];
              2'd2:    tx_nxt = JEDEC_ID[7:0];
              default: tx_nxt = 8'hFF;
            endcase
            idx_nxt = (idx == 2'd3) ? 2'd3 : idx + 2'd1;
          end
        end
      end
`endif
      S_IGNORE: miso_nxt = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
    // deselect overrides any ck edge seen in the same clock
    if (state != S_IDLE && cs_s) begin
      state_nxt = S_IDLE;
      rd_nxt    = 1'b0;
      a_nxt     = a_r;
      miso_nxt  = 1'b1;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cs_sy   <= 2'b11;
      ck_sy   <= 2'b00;
      mosi_sy <= 2'b00;
      cs_d    <= 1'b1;
      ck_d    <= 1'b0;
      cnt     <= '0;
      cmd_sh  <= '0;
      addr    <= '0;
      tx      <= 8'hFF;
      miso_r  <= 1'b1;
      rd_r    <= 1'b0;
      a_r     <= '0;
      cap     <= 1'b0;
`ifdef FLASH_RESPONDER_JEDEC_EN
      idx     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      cs_sy   <= {cs_sy[0], bus.cs};
      ck_sy   <= {ck_sy[0], bus.ck};
      mosi_sy <= {mosi_sy[0], bus.mosi};
      cs_d    <= cs_s;
      ck_d    <= ck_s;
      cnt     <= cnt_nxt;
      cmd_sh  <= cmd_nxt;
      addr    <= addr_nxt;
      tx      <= tx_nxt;
      miso_r  <= miso_nxt;
      rd_r    <= rd_nxt;
      a_r     <= a_nxt;
      cap     <= rd_r;
`ifdef FLASH_RESPONDER_JEDEC_EN
      idx     <= idx_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// Bench for flash_responder: SPI master driver, synchronous byte memory and a frame-level reference model.
module tb_flash_responder;
  localparam int          AW     = 24;
  localparam logic [7:0]  STATUS = 8'h00;
  localparam logic [23:0] JEDEC  = 24'hEF4018;
`ifdef FLASH_RESPONDER_JEDEC_EN
  localparam bit JEDEC_EN = 1'b1;
`else
  localparam bit JEDEC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  flash_responder_if #(.AW(AW)) bus();
  flash_responder #(.AW(AW), .STATUS(STATUS)) dut (.clock(clock), .reset(reset), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_a_q[$];
  logic [23:0] obs_a_q[$];
  logic        obs_q[$];
  logic [23:0] ea;
  bit          chk = 1'b0;
  bit          cap = 1'b0;
  logic        exp_miso = 1'b1;

  function automatic logic [7:0] mem_byte(input logic [23:0] ad);
    if (ad == 24'h00704D) return 8'h02;
    return (ad[7:0] * 8'd29) ^ ad[15:8] ^ {ad[19:16], ad[23:20]} ^ 8'hC3;
  endfunction

  always @(posedge clock) if (bus.rd) bus.q <= mem_byte(bus.a);

  // Expected miso at the master's sample point of bit i of a frame.
  function automatic logic model_miso(input logic [7:0] cmd, input logic [23:0] ad, input int i);
    int         start, j, k;
    logic [7:0] by;
    logic [7:0] t;
    start = (cmd == 8'h03) ? 32 : 8;
    if (i < start) return 1'b1;
    j = i - start;
    k = j / 8;
    case (cmd)
      8'h03:   by = mem_byte(ad + 24'(k));
      8'h05:   by = STATUS;
      8'h9F:   by = !JEDEC_EN ? 8'hFF : (k == 0) ? JEDEC[23:16] : (k == 1) ? JEDEC[15:8] :
                    (k == 2) ? JEDEC[7:0] : 8'hFF;
      default: by = 8'hFF;
    endcase
    t = by << (j % 8);
    return t[7];
  endfunction

  always @(negedge clock) begin
    if (bus.rd === 1'b1) begin
      obs_a_q.push_back(bus.a);
      tests++;
      if (exp_a_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: rd=1 a=%h, required no rd", bus.a);
      end else begin
        ea = exp_a_q.pop_front();
        if (bus.a !== ea) begin
          fails++;
          $display("FAIL rd_addr: a=%h, required %h", bus.a, ea);
        end
      end
    end
    if (chk) begin
      tests++;
      if (bus.miso !== exp_miso) begin
        fails++;
        $display("FAIL miso: got %b, required %b at %0t", bus.miso, exp_miso, $time);
      end
      if (cap) obs_q.push_back(bus.miso);
    end
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] obs_byte(input int first);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (first + i < obs_q.size()) ? obs_q[first + i] : 1'bx};
    return b;
  endfunction

  task automatic spi_bit(input logic mo, input logic ex, input bit collide);
    @(posedge clock); #2; bus.ck = 1'b0; bus.mosi = mo;
    repeat (3) @(posedge clock); #2; exp_miso = ex; chk = 1'b1; cap = 1'b1;
    @(posedge clock); #2; cap = 1'b0;
    @(posedge clock); #2; chk = 1'b0; bus.ck = 1'b1;
    if (collide) bus.cs = 1'b1;
    repeat (3) @(posedge clock); #2; chk = !collide;
    repeat (2) @(posedge clock); #2; chk = 1'b0;
  endtask

  // ending: 0 = cs rises after last bit, 1 = cs rises with last ck rise, 2 = reset mid-frame
  task automatic frame(input logic [7:0] cmd, input logic [23:0] ad, input int nbits, input int ending);
    int          rises;
    logic [31:0] hdr;
    logic        mo;
    obs_q.delete();
    obs_a_q.delete();
    rises = (ending == 1) ? nbits - 1 : nbits;
    if (cmd == 8'h03 && rises >= 32)
      for (int k = 0; k <= (rises - 32) / 8; k++) exp_a_q.push_back(ad + 24'(k));
    hdr = {cmd, ad};
    @(posedge clock); #2; bus.cs = 1'b0;
    repeat (4) @(posedge clock);
    for (int i = 0; i < nbits; i++) begin
      if (i < 32) begin
        mo  = hdr[31];
        hdr = hdr << 1;
      end else begin
        mo = 1'($urandom);
      end
      spi_bit(mo, model_miso(cmd, ad, i), ending == 1 && i == nbits - 1);
    end
    if (ending == 2) begin
      @(posedge clock); #2; reset = 1'b1; exp_miso = 1'b1; chk = 1'b1;
      repeat (4) @(posedge clock); #2; bus.cs = 1'b1; bus.ck = 1'b0;
      check("rst_rd", 24'(bus.rd), 24'h0);
      repeat (4) @(posedge clock); #2; reset = 1'b0;
      repeat (6) @(posedge clock); #2; chk = 1'b0;
    end else begin
      if (ending == 0) begin
        @(posedge clock); #2; bus.cs = 1'b1;
      end
      repeat (4) @(posedge clock); #2; bus.ck = 1'b0;
      exp_miso = 1'b1; chk = 1'b1;
      repeat (4) @(posedge clock); #2; chk = 1'b0;
    end
    repeat (4) @(posedge clock); #2;
    tests++;
    if (exp_a_q.size() != 0) begin
      fails++;
      $display("FAIL rd_count: %0d rd pulses missing, required 0", exp_a_q.size());
      exp_a_q.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rc;
    logic [23:0] ra;
    bus.cs = 1'b1; bus.ck = 1'b0; bus.mosi = 1'b0; bus.q = 8'h00;
    repeat (3) @(posedge clock); #2;
    check("reset_miso", 24'(bus.miso), 24'h1);
    check("reset_rd", 24'(bus.rd), 24'h0);
    check("reset_a", 24'(bus.a), 24'h0);
    reset = 1'b0;
    repeat (4) @(posedge clock); #2;

    frame(8'h03, 24'h00704D, 48, 0);
    check("read_b0", 24'(obs_byte(32)), 24'h02);
    check("read_b1", 24'(obs_byte(40)), 24'(mem_byte(24'h00704E)));
    check("read_rd_n", 24'(obs_a_q.size()), 24'd3);
    check("read_a0", obs_a_q[0], 24'h00704D);
    check("read_a1", obs_a_q[1], 24'h00704E);

    frame(8'h03, 24'hFFFFFF, 48, 0);
    check("wrap_a0", obs_a_q[0], 24'hFFFFFF);
    check("wrap_a1", obs_a_q[1], 24'h000000);
    check("wrap_b1", 24'(obs_byte(40)), 24'(mem_byte(24'h000000)));

    frame(8'h05, 24'($urandom), 32, 0);
    check("stat_b0", 24'(obs_byte(8)), 24'h00);
    check("stat_b2", 24'(obs_byte(24)), 24'h00);
    check("stat_rd_n", 24'(obs_a_q.size()), 24'd0);

    frame(8'h9F, 24'h0, 40, 0);
    check("id_b0", 24'(obs_byte(8)), JEDEC_EN ? 24'hEF : 24'hFF);
    check("id_b2", 24'(obs_byte(24)), JEDEC_EN ? 24'h18 : 24'hFF);
    check("id_b3", 24'(obs_byte(32)), 24'hFF);

    frame(8'hAB, 24'($urandom), 24, 0);
    check("unk_b1", 24'(obs_byte(8)), 24'hFF);
    frame(8'h03, 24'h000010, 40, 0);
    check("after_unk_b0", 24'(obs_byte(32)), 24'(mem_byte(24'h000010)));

    frame(8'h03, 24'($urandom), 20, 0);
    check("abort12_rd_n", 24'(obs_a_q.size()), 24'd0);
    frame(8'h03, 24'($urandom), 32, 1);
    check("collide_rd_n", 24'(obs_a_q.size()), 24'd0);
    frame(8'h03, 24'h00ABCD, 43, 2);
    check("rst_frame_rd_n", 24'(obs_a_q.size()), 24'd2);
    frame(8'h03, 24'h000123, 40, 0);
    check("post_rst_b0", 24'(obs_byte(32)), 24'(mem_byte(24'h000123)));

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'h03;
        1:       rc = 8'h05;
        2:       rc = 8'h9F;
        default: rc = 8'($urandom);
      endcase
      ra = 24'($urandom);
      frame(rc, ra, $urandom_range(4, 60), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
